// File: rtl/regfile_write_queue_if.sv
// Bundle of producer, register-file and bypass-lookup signals for regfile_write_queue.
// The queue sits on the slave modport; the producer/register-file side uses master.
interface regfile_write_queue_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              rf_ready;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] lookup_reg;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_reg, in_data, rf_ready, lookup_reg,
    input  in_ready, rf_wr_en, writeReg, writeData, lookup_hit, lookup_data, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, rf_ready, lookup_reg,
    output in_ready, rf_wr_en, writeReg, writeData, lookup_hit, lookup_data, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write staging FIFO in front of the 1R1W register file.
// Define REGFILE_WQ_BYPASS_EN to enable the youngest-match read bypass lookup.
module regfile_write_queue #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_reg_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full is taken from the registered count only, so in_ready never depends on rf_ready.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = bus.in_valid && !w_full;
  assign w_pop   = bus.rf_ready && !w_empty;

  // Pointer and occupancy state; reset wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the matching pointer makes them live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg_mem[r_wr_ptr]  <= bus.in_reg;
      r_data_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.rf_wr_en  = !w_empty;
  assign bus.writeReg  = w_empty ? {ADDR_W{1'b0}} : r_reg_mem[r_rd_ptr];
  assign bus.writeData = w_empty ? {DATA_W{1'b0}} : r_data_mem[r_rd_ptr];
  assign bus.count     = r_count;

`ifdef REGFILE_WQ_BYPASS_EN
  logic [DEPTH-1:0]  r_vld;
  logic              w_hit;
  logic [DATA_W-1:0] w_ldata;
  logic [PTR_W-1:0]  w_idx;

  // Per-entry occupancy flags searched by the bypass lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= {DEPTH{1'b0}};
    end else begin
      if (w_pop)  r_vld[r_rd_ptr] <= 1'b0;
      if (w_push) r_vld[r_wr_ptr] <= 1'b1;
    end
  end

  // Scan oldest to youngest from the head so the last match is the youngest write.
  always_comb begin
    w_hit   = 1'b0;
    w_ldata = {DATA_W{1'b0}};
    w_idx   = {PTR_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_vld[w_idx] && (r_reg_mem[w_idx] == bus.lookup_reg)) begin
        w_hit   = 1'b1;
        w_ldata = r_data_mem[w_idx];
      end else begin
        w_hit   = w_hit;
        w_ldata = w_ldata;
      end
    end
  end

  assign bus.lookup_hit  = w_hit;
  assign bus.lookup_data = w_ldata;
`else
  logic w_lookup_unused;

  assign w_lookup_unused = ^bus.lookup_reg;
  assign bus.lookup_hit  = 1'b0;
  assign bus.lookup_data = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue (ADDR_W=2, DATA_W=8, DEPTH=4); checks the
// bypass lookup against REGFILE_WQ_BYPASS_EN as compiled.
module tb_regfile_write_queue;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef REGFILE_WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR_W+DATA_W-1:0] sb [$];

  regfile_write_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  regfile_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    if (accept) sb.push_back({r, d});
    to_drive();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every drain handshake must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rf_wr_en === 1'b1 && bus.rf_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL drain_unexpected: got reg=%h data=%h, required no drain", bus.writeReg, bus.writeData);
        end else begin
          check("drain_order", {22'd0, bus.writeReg, bus.writeData}, {22'd0, sb.pop_front()});
        end
      end else if (bus.rf_wr_en === 1'b0) begin
        check("empty_head_zero", {22'd0, bus.writeReg, bus.writeData}, 32'd0);
      end
    end
  end

  initial begin
    // 1: reset with a request pending; it must be dropped
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg = 2'd1;
    bus.in_data = 8'h77;
    bus.rf_ready = 1'b0;
    bus.lookup_reg = 2'd0;
    to_drive();
    to_neg();
    check("rst_count_during", 32'(bus.count), 32'd0);
    check("rst_in_ready_during", 32'(bus.in_ready), 32'd1);
    to_drive();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    to_neg();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("rst_writeReg", 32'(bus.writeReg), 32'd0);
    check("rst_writeData", 32'(bus.writeData), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_lookup_hit", 32'(bus.lookup_hit), 32'd0);
    to_drive();

    // 2: fill, drop a push while full, then drain in order
    push(2'd1, 8'hA1, 1'b1);
    push(2'd2, 8'hB2, 1'b1);
    push(2'd3, 8'hC3, 1'b1);
    push(2'd0, 8'hD4, 1'b1);
    to_neg();
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    to_drive();
    push(2'd1, 8'hEE, 1'b0);
    to_neg();
    check("full_drop_count", 32'(bus.count), 32'd4);
    check("hold_head", {22'd0, bus.writeReg, bus.writeData}, {22'd0, 2'd1, 8'hA1});
    to_drive();
    bus.rf_ready = 1'b1;
    repeat (4) to_drive();
    to_neg();
    check("drained_count", 32'(bus.count), 32'd0);
    check("drained_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    check("drained_sb", 32'(sb.size()), 32'd0);
    to_drive();
    bus.rf_ready = 1'b0;

    // 3: simultaneous push and pop at count 2, pointers wrap
    push(2'd0, 8'h10, 1'b1);
    push(2'd1, 8'h11, 1'b1);
    bus.rf_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_reg   = 2'(i);
      bus.in_data  = 8'h30 + 8'(i);
      sb.push_back({bus.in_reg, bus.in_data});
      to_neg();
      check("simul_count", 32'(bus.count), 32'd2);
      to_drive();
    end
    bus.in_valid = 1'b0;
    to_neg();
    check("simul_count_end", 32'(bus.count), 32'd2);
    to_drive();
    to_drive();
    to_neg();
    check("simul_drained", 32'(bus.count), 32'd0);
    check("simul_sb", 32'(sb.size()), 32'd0);
    to_drive();
    bus.rf_ready = 1'b0;

    // 4/5: bypass lookup, youngest match wins
    push(2'd2, 8'h11, 1'b1);
    push(2'd1, 8'h22, 1'b1);
    push(2'd2, 8'h33, 1'b1);
    bus.lookup_reg = 2'd2;
    to_neg();
    check("byp_hit_r2", 32'(bus.lookup_hit), BYP ? 32'd1 : 32'd0);
    check("byp_data_r2", 32'(bus.lookup_data), BYP ? 32'h33 : 32'd0);
    to_drive();
    bus.lookup_reg = 2'd1;
    to_neg();
    check("byp_hit_r1", 32'(bus.lookup_hit), BYP ? 32'd1 : 32'd0);
    check("byp_data_r1", 32'(bus.lookup_data), BYP ? 32'h22 : 32'd0);
    to_drive();
    bus.lookup_reg = 2'd3;
    to_neg();
    check("byp_hit_r3", 32'(bus.lookup_hit), 32'd0);
    if (!BYP) check("byp_data_r3", 32'(bus.lookup_data), 32'd0);
    to_drive();
    bus.lookup_reg = 2'd2;
    bus.rf_ready = 1'b1;
    to_drive();
    to_drive();
    to_neg();
    check("byp_hit_partial", 32'(bus.lookup_hit), BYP ? 32'd1 : 32'd0);
    check("byp_data_partial", 32'(bus.lookup_data), BYP ? 32'h33 : 32'd0);
    to_drive();
    to_neg();
    check("byp_hit_drained", 32'(bus.lookup_hit), 32'd0);
    check("byp_count_drained", 32'(bus.count), 32'd0);
    to_drive();
    bus.rf_ready = 1'b0;

    // 6: reset while occupied, then a fresh push drains first
    push(2'd1, 8'h61, 1'b1);
    push(2'd2, 8'h62, 1'b1);
    push(2'd3, 8'h63, 1'b1);
    to_neg();
    check("mid_count_pre", 32'(bus.count), 32'd3);
    to_drive();
    rst_n = 1'b0;
    bus.rf_ready = 1'b1;
    sb.delete();
    to_drive();
    rst_n = 1'b1;
    to_neg();
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
    to_drive();
    push(2'd0, 8'h5A, 1'b1);
    to_neg();
    check("mid_first_head", {22'd0, bus.writeReg, bus.writeData}, {22'd0, 2'd0, 8'h5A});
    to_drive();
    to_neg();
    check("mid_final_count", 32'(bus.count), 32'd0);
    check("mid_final_sb", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
